// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer with a pedestrian walk phase. Greens extend while the
// opposite road is idle, roads alternate fairly, and a pending walk request pre-empts the next green.
module intersection_phase_scheduler #(
  parameter int unsigned CW        = 6,
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 30,
  parameter int unsigned YELLOW_T  = 5,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          req_ns,
  input  logic          req_ew,
  input  logic          ped_req,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          walk,
  output logic [2:0]    phase,
  output logic [CW-1:0] timer
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NS_G  = 3'd1,
    S_NS_Y  = 3'd2,
    S_ALL_R = 3'd3,
    S_EW_G  = 3'd4,
    S_EW_Y  = 3'd5,
    S_PED   = 3'd6
  } state_e;

  typedef enum logic {
    ROAD_NS = 1'b0,
    ROAD_EW = 1'b1
  } road_e;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  // Last-cycle timer values for each timed state.
  localparam logic [CW-1:0] T_GMIN = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] T_GMAX = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] T_Y    = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] T_AR   = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] T_W    = CW'(WALK_T - 1);

  state_e        state_q, state_d;
  road_e         last_q, last_d;
  logic          ped_pend_q, ped_pend_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [2:0]    ns_light_q, ns_light_d;
  logic [2:0]    ew_light_q, ew_light_d;
  logic          walk_q, walk_d;
  logic          hold_timer;
  logic          ns_other, ew_other;

  assign ns_other = req_ew | ped_pend_q;
  assign ew_other = req_ns | ped_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= ROAD_EW;
      ped_pend_q <= 1'b0;
      timer_q    <= '0;
      ns_light_q <= LAMP_R;
      ew_light_q <= LAMP_R;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ped_pend_q <= ped_pend_d;
      timer_q    <= timer_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      walk_q     <= walk_d;
    end
  end

  // Next-state, timer and walk-request bookkeeping.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_timer = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ALL_R;
      end
      S_NS_G: begin
        if (!enable)                          state_d = S_NS_Y;
        else if (ns_other && timer_q >= T_GMIN) state_d = S_NS_Y;
        else if (timer_q >= T_GMAX)             hold_timer = 1'b1;
      end
      S_EW_G: begin
        if (!enable)                          state_d = S_EW_Y;
        else if (ew_other && timer_q >= T_GMIN) state_d = S_EW_Y;
        else if (timer_q >= T_GMAX)             hold_timer = 1'b1;
      end
      S_NS_Y: begin
        if (timer_q == T_Y) begin
          state_d = S_ALL_R;
          last_d  = ROAD_NS;
        end
      end
      S_EW_Y: begin
        if (timer_q == T_Y) begin
          state_d = S_ALL_R;
          last_d  = ROAD_EW;
        end
      end
      S_ALL_R: begin
        if (timer_q == T_AR) begin
          if (!enable)                state_d = S_IDLE;
          else if (ped_pend_q)        state_d = S_PED;
          else if (last_q == ROAD_EW) state_d = S_NS_G;
          else                        state_d = S_EW_G;
        end
      end
      S_PED: begin
        if (timer_q == T_W) state_d = S_ALL_R;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
    else if (hold_timer)    timer_d = timer_q;
    else                    timer_d = timer_q + CW'(1);

    // Entering the walk consumes the request, even if the button is still held.
    if (state_d == S_PED && state_q != S_PED) ped_pend_d = 1'b0;
    else if (ped_req && state_q != S_PED)     ped_pend_d = 1'b1;
    else                                      ped_pend_d = ped_pend_q;
  end

  // Lamp codes registered from the next state so they always track state_q.
  always_comb begin
    ns_light_d = LAMP_R;
    ew_light_d = LAMP_R;
    walk_d     = 1'b0;
    case (state_d)
      S_NS_G:  ns_light_d = LAMP_G;
      S_NS_Y:  ns_light_d = LAMP_Y;
      S_EW_G:  ew_light_d = LAMP_G;
      S_EW_Y:  ew_light_d = LAMP_Y;
      S_PED:   walk_d     = 1'b1;
      default: ;
    endcase
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign phase    = state_q;
  assign timer    = timer_q;

endmodule
